// File: rtl/mult_pkg.sv
// Shared types and width helpers for the sequential multiplier datapath.
`default_nettype none

package mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  function automatic int clog2_int(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span * 2;
      result = result + 1;
    end
    return result;
  endfunction

  // Smallest accumulator that cannot wrap while summing count full-scale products.
  function automatic int acc_width_default(input int width, input int count);
    return 2 * width + clog2_int(count);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rise_detect.sv
// Generic single-bit rising-edge detector with a configurable history reset value.
`default_nettype none

module rise_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= RESET_VAL;
    end else begin
      prev_q <= d_i;
    end
  end

  assign rise_o = d_i & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/seq_mac_accumulator.sv
// Sums COUNT multiplier products sampled on ready edges and hands the total off via valid/ack.
`default_nettype none

module seq_mac_accumulator
  import mult_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int COUNT     = 4,
  parameter int ACC_WIDTH = acc_width_default(WIDTH, COUNT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic [2*WIDTH-1:0]     prod_in,
  input  logic                   prod_ready,
  output logic [ACC_WIDTH-1:0]   acc_out,
  output logic                   acc_valid,
  input  logic                   acc_ack,
  output logic                   busy,
  output logic                   overflow,
  output logic                   dropped
);

  localparam int          PAD_BITS = ACC_WIDTH + 1 - 2 * WIDTH;
  localparam logic [7:0]  LAST_CNT = 8'(COUNT - 1);

  state_t                 state_q;
  logic [ACC_WIDTH-1:0]   acc_q;
  logic [7:0]             cnt_q;
  logic [ACC_WIDTH-1:0]   acc_out_q;
  logic                   acc_valid_q;
  logic                   busy_q;
  logic                   overflow_q;
  logic                   dropped_q;

  logic                   rise;
  logic [ACC_WIDTH:0]     sum_d;
  logic                   last_d;

  // History resets high so a ready already asserted at reset release is not a new product.
  rise_detect #(
    .RESET_VAL (1'b1)
  ) u_rise (
    .clk    (clk),
    .rst    (rst),
    .d_i    (prod_ready),
    .rise_o (rise)
  );

  assign sum_d  = {1'b0, acc_q} + {{PAD_BITS{1'b0}}, prod_in};
  assign last_d = (cnt_q == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      acc_out_q   <= '0;
      acc_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clear) begin
            state_q    <= ST_ACCUM;
            busy_q     <= 1'b1;
            acc_q      <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            dropped_q  <= 1'b0;
          end else if (rise) begin
            dropped_q <= 1'b1;
          end
        end

        ST_ACCUM: begin
          if (clear) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            dropped_q  <= 1'b0;
          end else if (rise) begin
            acc_q <= sum_d[ACC_WIDTH-1:0];
            cnt_q <= cnt_q + 8'd1;
            if (sum_d[ACC_WIDTH]) begin
              overflow_q <= 1'b1;
            end
            if (last_d) begin
              acc_out_q   <= sum_d[ACC_WIDTH-1:0];
              acc_valid_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= ST_HOLD;
            end
          end
        end

        ST_HOLD: begin
          if (rise) begin
            dropped_q <= 1'b1;
          end
          if (acc_ack) begin
            acc_valid_q <= 1'b0;
            if (clear) begin
              state_q    <= ST_ACCUM;
              busy_q     <= 1'b1;
              acc_q      <= '0;
              cnt_q      <= '0;
              overflow_q <= 1'b0;
              dropped_q  <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          acc_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign acc_out   = acc_out_q;
  assign acc_valid = acc_valid_q;
  assign busy      = busy_q;
  assign overflow  = overflow_q;
  assign dropped   = dropped_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_mac_accumulator.sv
// Self-checking bench: three accumulator configurations driven by a product-pulse model.
`default_nettype none

module tb_seq_mac_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // A: COUNT=4, ACC_WIDTH=18
  logic        clear_a = 0, ready_a = 0, ack_a = 0;
  logic [15:0] prod_a = 0;
  logic [17:0] acc_out_a;
  logic        valid_a, busy_a, ovf_a, drop_a;
  // B: COUNT=2, ACC_WIDTH=16
  logic        clear_b = 0, ready_b = 0, ack_b = 0;
  logic [15:0] prod_b = 0;
  logic [15:0] acc_out_b;
  logic        valid_b, busy_b, ovf_b, drop_b;
  // C: COUNT=1, ACC_WIDTH=16
  logic        clear_c = 0, ready_c = 0, ack_c = 0;
  logic [15:0] prod_c = 0;
  logic [15:0] acc_out_c;
  logic        valid_c, busy_c, ovf_c, drop_c;

  int n_checks = 0;
  int n_fail   = 0;
  logic [17:0] exp_q[$];
  logic [17:0] exp_v;
  int cyc;

  seq_mac_accumulator #(.WIDTH(8), .COUNT(4), .ACC_WIDTH(18)) dut_a (
    .clk(clk), .rst(rst), .clear(clear_a), .prod_in(prod_a), .prod_ready(ready_a),
    .acc_out(acc_out_a), .acc_valid(valid_a), .acc_ack(ack_a), .busy(busy_a),
    .overflow(ovf_a), .dropped(drop_a));

  seq_mac_accumulator #(.WIDTH(8), .COUNT(2), .ACC_WIDTH(16)) dut_b (
    .clk(clk), .rst(rst), .clear(clear_b), .prod_in(prod_b), .prod_ready(ready_b),
    .acc_out(acc_out_b), .acc_valid(valid_b), .acc_ack(ack_b), .busy(busy_b),
    .overflow(ovf_b), .dropped(drop_b));

  seq_mac_accumulator #(.WIDTH(8), .COUNT(1), .ACC_WIDTH(16)) dut_c (
    .clk(clk), .rst(rst), .clear(clear_c), .prod_in(prod_c), .prod_ready(ready_c),
    .acc_out(acc_out_c), .acc_valid(valid_c), .acc_ack(ack_c), .busy(busy_c),
    .overflow(ovf_c), .dropped(drop_c));

  function automatic logic sel_valid(input int which);
    return (which == 0) ? valid_a : (which == 1) ? valid_b : valid_c;
  endfunction

  function automatic logic [17:0] sel_out(input int which);
    return (which == 0) ? acc_out_a : (which == 1) ? {2'b0, acc_out_b} : {2'b0, acc_out_c};
  endfunction

  task automatic set_ready(input int which, input logic v, input logic [15:0] p);
    case (which)
      0: begin ready_a = v; prod_a = p; end
      1: begin ready_b = v; prod_b = p; end
      default: begin ready_c = v; prod_c = p; end
    endcase
  endtask

  // One-cycle ready pulse; prod_in is scrambled afterwards since it is only meaningful on the rise.
  task automatic pulse(input int which, input logic [15:0] p);
    @(posedge clk); #1;
    set_ready(which, 1'b1, p);
    @(posedge clk); #1;
    set_ready(which, 1'b0, 16'($urandom));
  endtask

  task automatic do_clear(input int which);
    @(posedge clk); #1;
    case (which)
      0: clear_a = 1'b1;
      1: clear_b = 1'b1;
      default: clear_c = 1'b1;
    endcase
    @(posedge clk); #1;
    clear_a = 1'b0; clear_b = 1'b0; clear_c = 1'b0;
  endtask

  task automatic do_ack(input int which);
    @(posedge clk); #1;
    case (which)
      0: ack_a = 1'b1;
      1: ack_b = 1'b1;
      default: ack_c = 1'b1;
    endcase
    @(posedge clk); #1;
    ack_a = 1'b0; ack_b = 1'b0; ack_c = 1'b0;
  endtask

  task automatic wait_valid(input int which, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!sel_valid(which) && cycles < 20);
  endtask

  task automatic pop_expected(output logic [17:0] v);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries, required at least 1");
      v = '0;
    end else begin
      v = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({acc_out_a, valid_a, busy_a, ovf_a, drop_a} !== 22'd0) begin
      n_fail++; $display("FAIL reset_a: got out=%0d v=%b b=%b o=%b d=%b, required all 0",
                         acc_out_a, valid_a, busy_a, ovf_a, drop_a);
    end
    n_checks++;
    if ({acc_out_b, valid_b, busy_b, ovf_b, drop_b, acc_out_c, valid_c, busy_c, ovf_c, drop_c} !== 40'd0) begin
      n_fail++; $display("FAIL reset_bc: got nonzero outputs, required all 0");
    end
  endtask

  task automatic test_basic();
    do_clear(0);
    @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b required 1", busy_a); end
    exp_q.push_back(18'd65151);
    pulse(0, 16'd6); pulse(0, 16'd20); pulse(0, 16'd100); pulse(0, 16'd65025);
    wait_valid(0, cyc);
    n_checks++;
    if (cyc !== 1) begin n_fail++; $display("FAIL basic_latency: got %0d cycles required 1", cyc); end
    pop_expected(exp_v);
    n_checks++;
    if (acc_out_a !== exp_v) begin n_fail++; $display("FAIL basic_sum: got %0d required %0d", acc_out_a, exp_v); end
    n_checks++;
    if (ovf_a !== 1'b0 || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL basic_flags: got ovf=%b busy=%b required 0 0", ovf_a, busy_a);
    end
    do_ack(0);
    @(negedge clk);
    n_checks++;
    if (valid_a !== 1'b0 || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL basic_ack: got valid=%b busy=%b required 0 0", valid_a, busy_a);
    end
  endtask

  task automatic test_level_ready();
    do_clear(0);
    @(posedge clk); #1;
    set_ready(0, 1'b1, 16'd50);
    repeat (10) @(posedge clk);
    #1 set_ready(0, 1'b0, 16'd50);
    @(posedge clk); #1;
    set_ready(0, 1'b1, 16'd50);
    repeat (4) @(posedge clk);
    #1 set_ready(0, 1'b0, 16'd0);
    @(negedge clk);
    n_checks++;
    if (valid_a !== 1'b0 || busy_a !== 1'b1) begin
      n_fail++; $display("FAIL level_two_counted: got valid=%b busy=%b required 0 1", valid_a, busy_a);
    end
    exp_q.push_back(18'd116);
    pulse(0, 16'd7); pulse(0, 16'd9);
    wait_valid(0, cyc);
    pop_expected(exp_v);
    n_checks++;
    if (acc_out_a !== exp_v) begin n_fail++; $display("FAIL level_sum: got %0d required %0d", acc_out_a, exp_v); end
    do_ack(0);
  endtask

  task automatic test_overflow();
    do_clear(1);
    exp_q.push_back(18'd64514);
    pulse(1, 16'd65025); pulse(1, 16'd65025);
    wait_valid(1, cyc);
    pop_expected(exp_v);
    n_checks++;
    if ({2'b0, acc_out_b} !== exp_v) begin n_fail++; $display("FAIL ovf_sum: got %0d required %0d", acc_out_b, exp_v); end
    n_checks++;
    if (ovf_b !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b required 1", ovf_b); end
    do_ack(1);
    do_clear(1);
    @(negedge clk);
    n_checks++;
    if (ovf_b !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared: got %b required 0", ovf_b); end
  endtask

  task automatic test_drops();
    pulse(0, 16'd500);
    @(negedge clk);
    n_checks++;
    if (drop_a !== 1'b1 || busy_a !== 1'b0 || valid_a !== 1'b0) begin
      n_fail++; $display("FAIL drop_idle: got d=%b b=%b v=%b required 1 0 0", drop_a, busy_a, valid_a);
    end
    do_clear(0);
    @(negedge clk);
    n_checks++;
    if (drop_a !== 1'b0) begin n_fail++; $display("FAIL drop_clear1: got %b required 0", drop_a); end
    exp_q.push_back(18'd8);
    repeat (4) pulse(0, 16'd2);
    wait_valid(0, cyc);
    pop_expected(exp_v);
    n_checks++;
    if (acc_out_a !== exp_v) begin n_fail++; $display("FAIL drop_sum: got %0d required %0d", acc_out_a, exp_v); end
    pulse(0, 16'd999);
    @(negedge clk);
    n_checks++;
    if (drop_a !== 1'b1 || acc_out_a !== 18'd8 || valid_a !== 1'b1) begin
      n_fail++; $display("FAIL drop_hold: got d=%b out=%0d v=%b required 1 8 1", drop_a, acc_out_a, valid_a);
    end
    do_clear(0);
    @(negedge clk);
    n_checks++;
    if (valid_a !== 1'b1 || busy_a !== 1'b0 || acc_out_a !== 18'd8) begin
      n_fail++; $display("FAIL hold_clear_ignored: got v=%b b=%b out=%0d required 1 0 8", valid_a, busy_a, acc_out_a);
    end
    do_ack(0);
    do_clear(0);
    @(negedge clk);
    n_checks++;
    if (drop_a !== 1'b0 || busy_a !== 1'b1) begin
      n_fail++; $display("FAIL drop_clear2: got d=%b b=%b required 0 1", drop_a, busy_a);
    end
  endtask

  task automatic test_reset_mid();
    pulse(0, 16'd1); pulse(0, 16'd1);
    @(posedge clk); #1;
    set_ready(0, 1'b1, 16'd1);
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy_a !== 1'b0 || valid_a !== 1'b0 || acc_out_a !== 18'd0) begin
      n_fail++; $display("FAIL reset_async: got b=%b v=%b out=%0d required 0 0 0", busy_a, valid_a, acc_out_a);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (drop_a !== 1'b0 || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready_high: got d=%b b=%b required 0 0", drop_a, busy_a);
    end
    @(posedge clk); #1;
    set_ready(0, 1'b0, 16'd0);
    do_clear(0);
    exp_q.push_back(18'd4);
    repeat (4) pulse(0, 16'd1);
    wait_valid(0, cyc);
    pop_expected(exp_v);
    n_checks++;
    if (acc_out_a !== exp_v) begin n_fail++; $display("FAIL reset_fresh_sum: got %0d required %0d", acc_out_a, exp_v); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    ack_a = 1'b1; clear_a = 1'b1;
    @(posedge clk); #1;
    ack_a = 1'b0; clear_a = 1'b0;
    @(negedge clk);
    n_checks++;
    if (valid_a !== 1'b0 || busy_a !== 1'b1) begin
      n_fail++; $display("FAIL b2b_restart: got v=%b b=%b required 0 1", valid_a, busy_a);
    end
    exp_q.push_back(18'd12);
    repeat (4) pulse(0, 16'd3);
    wait_valid(0, cyc);
    pop_expected(exp_v);
    n_checks++;
    if (acc_out_a !== exp_v) begin n_fail++; $display("FAIL b2b_sum: got %0d required %0d", acc_out_a, exp_v); end
    do_ack(0);
  endtask

  task automatic test_count_one();
    do_clear(2);
    exp_q.push_back(18'd200);
    pulse(2, 16'd200);
    wait_valid(2, cyc);
    n_checks++;
    if (cyc !== 1) begin n_fail++; $display("FAIL count1_latency: got %0d cycles required 1", cyc); end
    pop_expected(exp_v);
    n_checks++;
    if ({2'b0, acc_out_c} !== exp_v) begin n_fail++; $display("FAIL count1_sum: got %0d required %0d", acc_out_c, exp_v); end
    do_ack(2);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    test_basic();
    test_level_ready();
    test_overflow();
    test_drops();
    test_reset_mid();
    test_back_to_back();
    test_count_one();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover: got %0d entries required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before end of test");
    $fatal(1);
  end

endmodule

`default_nettype wire
